// File: rtl/mz_pulse_sequencer.sv
// mz_pulse_sequencer: trigger-started pi/2 - (pi)xN - pi/2 RF gate train.
// N=0 gives a Ramsey pair, N=1 a Mach-Zehnder gate, N>1 CPMG spacing.
// Free-evolution interval, pi count and repeat mode are latched when a run starts.
module mz_pulse_sequencer #(
    parameter int CNT_W      = 32,
    parameter int WAIT_W     = 24,
    parameter int NPI_W      = 4,
    parameter int PRE_DELAY  = 33300,
    parameter int PI2_LEN    = 333,
    parameter int PI_LEN     = 666,
    parameter int POST_DELAY = 33300
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic              abort,
    input  logic [WAIT_W-1:0] cfg_wait,
    input  logic [NPI_W-1:0]  cfg_n_pi,
    input  logic              cfg_repeat,
    output logic              rf,
    output logic              busy,
    output logic              done,
    output logic [15:0]       seq_count,
    output logic [2:0]        phase
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_PI2A = 3'd2,
        ST_WAIT = 3'd3,
        ST_PI   = 3'd4,
        ST_PI2B = 3'd5,
        ST_POST = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NPI_W-1:0]  NPI_ZERO = {NPI_W{1'b0}};
    localparam logic [NPI_W-1:0]  NPI_ONE  = {{(NPI_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] W_ZERO   = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] W_ONE    = {{(WAIT_W-1){1'b0}}, 1'b1};

    logic              sync1_q, sync2_q, trig_prev_q;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, len_s;
    logic [NPI_W-1:0]  pi_cnt_q, pi_cnt_d, n_q, n_d;
    logic [WAIT_W-1:0] w_q, w_d, cfg_w_eff_s;
    logic              rep_q, rep_d;
    logic              rf_q, rf_d, busy_q, busy_d, done_q, done_d;
    logic [15:0]       seq_count_q, seq_count_d;
    logic              trig_rise_s, last_s, wait_inner_s;

    // Two-flop synchroniser plus one history flop for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            trig_prev_q <= 1'b0;
        end else begin
            sync1_q     <= trig;
            sync2_q     <= sync1_q;
            trig_prev_q <= sync2_q;
        end
    end

    assign trig_rise_s  = sync2_q & ~trig_prev_q;
    // A zero interval would make WAIT last no cycles at all; run it as one cycle
    assign cfg_w_eff_s  = (cfg_wait == W_ZERO) ? W_ONE : cfg_wait;
    // A WAIT sits between two pi gates when at least one pi is done and more remain
    assign wait_inner_s = (pi_cnt_q != NPI_ZERO) && (pi_cnt_q != n_q);

    // Length in cycles of the phase currently running
    always_comb begin
        len_s = CNT_ONE;
        case (state_q)
            ST_PRE:           len_s = CNT_W'(PRE_DELAY);
            ST_PI2A, ST_PI2B: len_s = CNT_W'(PI2_LEN);
            ST_WAIT:          len_s = wait_inner_s ? CNT_W'({w_q, 1'b0}) : CNT_W'(w_q);
            ST_PI:            len_s = CNT_W'(PI_LEN);
            ST_POST:          len_s = CNT_W'(POST_DELAY);
            default:          len_s = CNT_ONE;
        endcase
    end

    assign last_s = (cnt_q == (len_s - CNT_ONE));

    // Next-state, phase counter, config latch and completion bookkeeping
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_ONE;
        pi_cnt_d    = pi_cnt_q;
        w_d         = w_q;
        n_d         = n_q;
        rep_d       = rep_q;
        done_d      = 1'b0;
        seq_count_d = seq_count_q;
        if (state_q == ST_IDLE) begin
            cnt_d = CNT_ZERO;
            // abort on the same edge as a trigger edge keeps the block idle
            if (trig_rise_s && !abort) begin
                state_d  = ST_PRE;
                pi_cnt_d = NPI_ZERO;
                w_d      = cfg_w_eff_s;
                n_d      = cfg_n_pi;
                rep_d    = cfg_repeat;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
        end else if (last_s) begin
            cnt_d = CNT_ZERO;
            case (state_q)
                ST_PRE:  state_d = ST_PI2A;
                ST_PI2A: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (pi_cnt_q < n_q) begin
                        state_d = ST_PI;
                    end else begin
                        state_d = ST_PI2B;
                    end
                end
                ST_PI: begin
                    pi_cnt_d = pi_cnt_q + NPI_ONE;
                    state_d  = ST_WAIT;
                end
                ST_PI2B: state_d = ST_POST;
                ST_POST: begin
                    done_d      = 1'b1;
                    seq_count_d = seq_count_q + 16'd1;
                    // Repeat mode re-runs on the level of trig, not a new edge
                    if (rep_q && sync2_q) begin
                        state_d  = ST_PRE;
                        pi_cnt_d = NPI_ZERO;
                        w_d      = cfg_w_eff_s;
                        n_d      = cfg_n_pi;
                        rep_d    = cfg_repeat;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output decode from the next state so rf and busy are registered yet aligned with phase
    always_comb begin
        rf_d   = (state_d == ST_PI2A) || (state_d == ST_PI) || (state_d == ST_PI2B);
        busy_d = (state_d != ST_IDLE);
    end

    // State, counters, latched config and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            pi_cnt_q    <= NPI_ZERO;
            w_q         <= W_ZERO;
            n_q         <= NPI_ZERO;
            rep_q       <= 1'b0;
            rf_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            seq_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pi_cnt_q    <= pi_cnt_d;
            w_q         <= w_d;
            n_q         <= n_d;
            rep_q       <= rep_d;
            rf_q        <= rf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            seq_count_q <= seq_count_d;
        end
    end

    assign rf        = rf_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign seq_count = seq_count_q;
    assign phase     = state_q;

endmodule

// File: tb/tb_mz_pulse_sequencer.sv
// Bench for mz_pulse_sequencer: a reference model turns each run's config into
// the expected rf low-gap / high-run lengths and done counts; a monitor
// measures what the DUT produces and compares against those queues.
module tb_mz_pulse_sequencer;

    localparam int PRE    = 4;
    localparam int PI2    = 3;
    localparam int PI     = 6;
    localparam int POST   = 4;
    localparam int WAIT_W = 24;
    localparam int NPI_W  = 4;

    logic              clk = 1'b0;
    logic              rst, trig, abort, cfg_repeat;
    logic [WAIT_W-1:0] cfg_wait;
    logic [NPI_W-1:0]  cfg_n_pi;
    logic              rf, busy, done;
    logic [15:0]       seq_count;
    logic [2:0]        phase;

    int tests = 0;
    int fails = 0;
    int exp_gap_q[$];
    int exp_run_q[$];
    int exp_done_q[$];
    int model_count = 0;
    int done_seen   = 0;
    int mon_gap = 0;
    int mon_run = 0;
    logic mon_prev_rf = 1'b0;
    logic mon_prev_busy = 1'b0;

    always #5 clk = ~clk;

    mz_pulse_sequencer #(
        .CNT_W(32), .WAIT_W(WAIT_W), .NPI_W(NPI_W),
        .PRE_DELAY(PRE), .PI2_LEN(PI2), .PI_LEN(PI), .POST_DELAY(POST)
    ) dut (
        .clk(clk), .rst(rst), .trig(trig), .abort(abort),
        .cfg_wait(cfg_wait), .cfg_n_pi(cfg_n_pi), .cfg_repeat(cfg_repeat),
        .rf(rf), .busy(busy), .done(done), .seq_count(seq_count), .phase(phase)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: one run as alternating low gaps and high runs
    task automatic push_seq(input int w, input int n, input bit first);
        int we;
        we = (w == 0) ? 1 : w;
        exp_gap_q.push_back(first ? PRE : POST + PRE);
        exp_run_q.push_back(PI2);
        for (int i = 1; i <= n; i++) begin
            exp_gap_q.push_back((i == 1) ? we : 2 * we);
            exp_run_q.push_back(PI);
        end
        exp_gap_q.push_back(we);
        exp_run_q.push_back(PI2);
        model_count = (model_count + 1) & 16'hFFFF;
        exp_done_q.push_back(model_count);
    endtask

    function automatic int seq_len(input int w, input int n);
        int we;
        we = (w == 0) ? 1 : w;
        return PRE + 2 * PI2 + n * PI + ((n == 0) ? we : 2 * n * we) + POST;
    endfunction

    // Monitor: measure rf gaps/runs and done pulses, compare to the queues
    always @(negedge clk) begin
        if (rst) begin
            mon_gap = 0; mon_run = 0; mon_prev_rf = 1'b0; mon_prev_busy = 1'b0;
        end else begin
            if (busy && !mon_prev_busy) mon_gap = 0;
            if (rf) begin
                if (!mon_prev_rf) begin
                    if (exp_gap_q.size() == 0) check("sb_gap_unexpected", mon_gap, -1);
                    else check("sb_gap", mon_gap, exp_gap_q.pop_front());
                    mon_run = 1;
                end else begin
                    mon_run++;
                end
            end else begin
                if (mon_prev_rf) begin
                    if (exp_run_q.size() == 0) check("sb_run_unexpected", mon_run, -1);
                    else check("sb_run", mon_run, exp_run_q.pop_front());
                    mon_gap = 0;
                end
                if (busy) mon_gap++;
            end
            if (done) begin
                done_seen++;
                if (exp_done_q.size() == 0) check("sb_done_unexpected", seq_count, -1);
                else check("sb_done_count", seq_count, exp_done_q.pop_front());
            end
            mon_prev_rf = rf;
            mon_prev_busy = busy;
        end
    end

    task automatic wait_busy(input int budget);
        int k;
        k = 0;
        while (!busy && k < budget) begin @(negedge clk); k++; end
        check("start_timeout", busy, 1);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin @(negedge clk); k++; end
        check("finish_timeout", busy, 0);
    endtask

    task automatic drain_check(input string name);
        check(name, exp_gap_q.size() + exp_run_q.size() + exp_done_q.size(), 0);
    endtask

    task automatic run_single(input int w, input int n);
        @(negedge clk);
        cfg_wait = WAIT_W'(w); cfg_n_pi = NPI_W'(n); cfg_repeat = 1'b0;
        push_seq(w, n, 1'b1);
        trig = 1'b1;
        repeat (2) @(negedge clk);
        trig = 1'b0;
        wait_busy(10);
        repeat (2) @(negedge clk);
        // mid-run config changes must not alter the train
        cfg_wait = WAIT_W'($urandom_range(0, 9));
        cfg_n_pi = NPI_W'($urandom_range(0, 5));
        cfg_repeat = 1'($urandom_range(0, 1));
        wait_idle(5000);
        repeat (2) @(negedge clk);
        drain_check("drain_single");
        check("seq_count_single", seq_count, model_count);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nseq, dbefore, lseq;
        rst = 1'b1; trig = 1'b0; abort = 1'b0;
        cfg_wait = '0; cfg_n_pi = '0; cfg_repeat = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rf", rf, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", seq_count, 0);
        check("rst_phase", phase, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: W=10, N=1, absolute edge timing from E0
        cfg_wait = 24'd10; cfg_n_pi = 4'd1; cfg_repeat = 1'b0;
        push_seq(10, 1, 1'b1);
        trig = 1'b1;
        for (int k = 0; k <= 44; k++) begin
            @(posedge clk); #1;
            if (k == 2) trig = 1'b0;
            check($sformatf("t1_rf_E%0d", k), rf,
                  ((k >= 6 && k <= 8) || (k >= 19 && k <= 24) || (k >= 35 && k <= 37)) ? 1 : 0);
            check($sformatf("t1_done_E%0d", k), done, (k == 42) ? 1 : 0);
            if (k != 42) check($sformatf("t1_busy_E%0d", k), busy, (k >= 2 && k <= 41) ? 1 : 0);
            if (k == 2)  check("t1_phase_pre", phase, 1);
            if (k == 6)  check("t1_phase_pi2a", phase, 2);
            if (k == 9)  check("t1_phase_wait", phase, 3);
            if (k == 19) check("t1_phase_pi", phase, 4);
            if (k == 35) check("t1_phase_pi2b", phase, 5);
            if (k == 38) check("t1_phase_post", phase, 6);
            if (k == 43) check("t1_phase_idle", phase, 0);
        end
        wait_idle(100);
        repeat (2) @(negedge clk);
        drain_check("t1_drain");
        check("t1_count", seq_count, 1);

        // 2: CPMG spacing, 3: Ramsey with W=0
        run_single(5, 3);
        run_single(0, 0);

        // randomized runs against the model
        for (int i = 0; i < 8; i++) run_single($urandom_range(0, 8), $urandom_range(0, 4));

        // 4: repeat mode with trig held high for 100 edges
        @(negedge clk);
        cfg_wait = 24'd10; cfg_n_pi = 4'd1; cfg_repeat = 1'b1;
        lseq = seq_len(10, 1);
        nseq = 1;
        while (lseq * nseq <= 99) nseq++;
        for (int s = 0; s < nseq; s++) push_seq(10, 1, (s == 0));
        dbefore = done_seen;
        trig = 1'b1;
        repeat (100) @(negedge clk);
        trig = 1'b0;
        wait_idle(2000);
        repeat (2) @(negedge clk);
        check("t4_done_pulses", done_seen - dbefore, nseq);
        check("t4_count", seq_count, model_count);
        drain_check("t4_drain");
        cfg_repeat = 1'b0;

        // 5: abort sampled at E20, inside the pi gate
        @(negedge clk);
        cfg_wait = 24'd10; cfg_n_pi = 4'd1;
        exp_gap_q.push_back(PRE); exp_run_q.push_back(PI2);
        exp_gap_q.push_back(10);  exp_run_q.push_back(20 - (2 + PRE + PI2 + 10));
        dbefore = done_seen;
        trig = 1'b1;
        repeat (20) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(posedge clk); #1;
        check("t5_rf_E21", rf, 0);
        check("t5_busy_E21", busy, 0);
        check("t5_phase_E21", phase, 0);
        repeat (5) @(negedge clk);
        check("t5_no_restart", busy, 0);
        check("t5_no_done", done_seen - dbefore, 0);
        check("t5_count", seq_count, model_count);
        drain_check("t5_drain");
        trig = 1'b0;
        repeat (3) @(negedge clk);
        run_single(10, 1);

        // abort together with a trigger edge while idle
        @(negedge clk);
        abort = 1'b1; trig = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_abort_busy", busy, 0);
        abort = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_abort_phase", phase, 0);
        check("idle_abort_no_edge", busy, 0);
        trig = 1'b0;
        repeat (3) @(negedge clk);

        // 6a: seq_count preset to 0xFFFF, second trigger edge while busy
        force dut.seq_count_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.seq_count_q;
        model_count = 16'hFFFF;
        cfg_wait = 24'd2; cfg_n_pi = 4'd1; cfg_repeat = 1'b0;
        push_seq(2, 1, 1'b1);
        dbefore = done_seen;
        trig = 1'b1;
        repeat (2) @(negedge clk);
        trig = 1'b0;
        repeat (8) @(negedge clk);
        trig = 1'b1;
        repeat (2) @(negedge clk);
        trig = 1'b0;
        wait_idle(500);
        repeat (6) @(negedge clk);
        check("t6_single_done", done_seen - dbefore, 1);
        check("t6_wrap", seq_count, 0);
        check("t6_no_second_run", busy, 0);
        drain_check("t6_drain");

        // 6b: asynchronous reset in the middle of WAIT
        cfg_wait = 24'd20; cfg_n_pi = 4'd0;
        exp_gap_q.push_back(PRE); exp_run_q.push_back(PI2);
        trig = 1'b1;
        repeat (2) @(negedge clk);
        trig = 1'b0;
        repeat (14) @(negedge clk);
        check("t6_in_wait", phase, 3);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_rf", rf, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_phase", phase, 0);
        drain_check("t6_pre_rst_drain");
        exp_gap_q.delete(); exp_run_q.delete(); exp_done_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_count = 0;
        check("t6_rst_count", seq_count, 0);
        repeat (2) @(negedge clk);
        run_single(3, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
